// File: rtl/fpga_cfg_pkg.sv
// Shared configuration for the inverse-normal-CDF pipeline.
// Holds the fixed-point format, the tail threshold, the per-lane fold result
// record and the fold-stage buffer state encoding.
package fpga_cfg_pkg;

  localparam int unsigned FP_WIDTH   = 32;
  localparam int unsigned FP_QFRAC   = 16;
  localparam int unsigned ICDF_P_LOW = 1589;  // 0.02425 in Q16.16

  // Result of folding one lane; also the storage format of main/skid slots.
  typedef struct packed {
    logic [FP_WIDTH-1:0] x;
    logic                negate;
    logic                tail;
    logic                range_err;
  } icdf_fold_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fold_buf_state_t;

endpackage

// File: rtl/icdf_fold_lane.sv
// Combinational single-lane fold of a uniform u in [0,1] onto x in [0,0.5].
// Optional feature macro: FOLD_EPS_CLAMP_EN (replace a folded x of 0 by one LSB).
// Ports:
//   u    in   WIDTH         unsigned uniform, Q(WIDTH-QFRAC).QFRAC
//   fold out  icdf_fold_t   {x, negate, tail, range_err}
module icdf_fold_lane
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned WIDTH = FP_WIDTH,
  parameter int unsigned QFRAC = FP_QFRAC,
  parameter int unsigned P_LOW = ICDF_P_LOW
) (
  input  logic [WIDTH-1:0] u,
  output icdf_fold_t       fold
);

  localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1) << QFRAC;
  localparam logic [WIDTH-1:0] HALF_V  = WIDTH'(1) << (QFRAC - 1);
  localparam logic [WIDTH-1:0] P_LOW_V = WIDTH'(P_LOW);

  logic             over;
  logic [WIDTH-1:0] u_cl;
  logic [WIDTH-1:0] x_fold;
  logic             neg;

  // Clamp above ONE, then reflect the upper half; ONE - u_cl cannot underflow.
  always_comb begin
    over   = (u > ONE_V);
    u_cl   = over ? ONE_V : u;
    x_fold = u_cl;
    neg    = 1'b0;
    if (u_cl >= HALF_V) begin
      x_fold = ONE_V - u_cl;
      neg    = 1'b1;
    end
`ifdef FOLD_EPS_CLAMP_EN
    // Keep the downstream log() finite.
    if (x_fold == '0) begin
      x_fold = WIDTH'(1);
    end
`endif
  end

  always_comb begin
    fold           = '0;
    fold.x         = FP_WIDTH'(x_fold);
    fold.negate    = neg;
    fold.tail      = (x_fold < P_LOW_V);
    fold.range_err = over;
  end

endmodule

// File: rtl/inverse_cdf_fold_lanes.sv
// Multi-lane fold stage of the inverse-normal-CDF pipeline with a 2-entry skid
// buffer behind one shared valid/ready handshake. Latency 1 cycle.
// Optional feature macro: FOLD_EPS_CLAMP_EN (handled inside icdf_fold_lane).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   valid_in/ready_out   upstream handshake (ready_out registered)
//   u, tag_in            LANES uniforms (lane i at [i*WIDTH +: WIDTH]) and beat tag
//   valid_out/ready_in   downstream handshake
//   x, negate, tail,     per-lane fold results of the presented beat
//   range_err, tag_out
module inverse_cdf_fold_lanes
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned WIDTH = FP_WIDTH,
  parameter int unsigned QFRAC = FP_QFRAC,
  parameter int unsigned LANES = 4,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned P_LOW = ICDF_P_LOW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [LANES*WIDTH-1:0] u,
  input  logic [TAG_W-1:0]       tag_in,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [LANES*WIDTH-1:0] x,
  output logic [LANES-1:0]       negate,
  output logic [LANES-1:0]       tail,
  output logic [LANES-1:0]       range_err,
  output logic [TAG_W-1:0]       tag_out
);

  icdf_fold_t [LANES-1:0] fold_c;
  icdf_fold_t [LANES-1:0] main_q;
  icdf_fold_t [LANES-1:0] skid_q;
  logic [TAG_W-1:0]       main_tag;
  logic [TAG_W-1:0]       skid_tag;

  fold_buf_state_t state, state_nx;
  logic accept, transfer;
  logic load_main, load_skid, skid_to_main;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    icdf_fold_lane #(
      .WIDTH(WIDTH),
      .QFRAC(QFRAC),
      .P_LOW(P_LOW)
    ) u_lane (
      .u   (u[i*WIDTH +: WIDTH]),
      .fold(fold_c[i])
    );
  end

  assign accept   = valid_in & ready_out;
  assign transfer = valid_out & ready_in;

  // Buffer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and slot load controls.
  always_comb begin
    state_nx     = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nx  = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && transfer) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_nx  = ST_FULL;
          load_skid = 1'b1;
        end else if (transfer) begin
          state_nx  = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (transfer) begin
          state_nx     = ST_ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

  // Handshake flags and main/skid slots; reset discards any held beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      ready_out <= 1'b1;
      main_q    <= '0;
      main_tag  <= '0;
      skid_q    <= '0;
      skid_tag  <= '0;
    end else begin
      valid_out <= (state_nx != ST_EMPTY);
      ready_out <= (state_nx != ST_FULL);
      if (load_main) begin
        main_q   <= fold_c;
        main_tag <= tag_in;
      end else if (skid_to_main) begin
        main_q   <= skid_q;
        main_tag <= skid_tag;
      end
      if (load_skid) begin
        skid_q   <= fold_c;
        skid_tag <= tag_in;
      end
    end
  end

  // Unpack the main slot onto the lane-major output buses.
  always_comb begin
    x         = '0;
    negate    = '0;
    tail      = '0;
    range_err = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      x[i*WIDTH +: WIDTH] = WIDTH'(main_q[i].x);
      negate[i]           = main_q[i].negate;
      tail[i]             = main_q[i].tail;
      range_err[i]        = main_q[i].range_err;
    end
  end

  assign tag_out = main_tag;

endmodule

// File: tb/tb_inverse_cdf_fold_lanes.sv
// Self-checking bench for inverse_cdf_fold_lanes: directed cases plus random
// traffic checked against a queue-based reference model.
module tb_inverse_cdf_fold_lanes;

`ifdef FOLD_EPS_CLAMP_EN
  localparam bit EPS = 1'b1;
`else
  localparam bit EPS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic         ready_out;
  logic [127:0] u;
  logic [7:0]   tag_in;
  logic         valid_out;
  logic         ready_in;
  logic [127:0] x;
  logic [3:0]   negate;
  logic [3:0]   tail;
  logic [3:0]   range_err;
  logic [7:0]   tag_out;

  inverse_cdf_fold_lanes dut (
    .clk      (clk),
    .rst      (rst),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .u        (u),
    .tag_in   (tag_in),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .x        (x),
    .negate   (negate),
    .tail     (tail),
    .range_err(range_err),
    .tag_out  (tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] x;
    logic [3:0]   neg;
    logic [3:0]   tail;
    logic [3:0]   err;
    logic [7:0]   tag;
  } beat_t;

  beat_t      q[$];
  logic [7:0] delivered[$];
  int         n_vec = 0;
  int         n_miss = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Fold rule in plain arithmetic: returns {x[31:0], negate, tail, range_err}.
  function automatic logic [34:0] fold_ref(input logic [31:0] uin);
    longint unsigned uc, xv;
    bit ng, er;
    er = (uin > 32'h10000);
    uc = er ? 64'h10000 : 64'(uin);
    if (uc < 64'h8000) begin
      xv = uc; ng = 1'b0;
    end else begin
      xv = 64'h10000 - uc; ng = 1'b1;
    end
    if (EPS && xv == 0) xv = 1;
    return {32'(xv), ng, (xv < 64'd1589), er};
  endfunction

  function automatic beat_t make_beat(input logic [127:0] uv, input logic [7:0] tg);
    beat_t b;
    logic [34:0] r;
    b.x = '0; b.neg = '0; b.tail = '0; b.err = '0; b.tag = tg;
    for (int i = 0; i < 4; i++) begin
      r = fold_ref(uv[i*32 +: 32]);
      b.x[i*32 +: 32] = r[34:3];
      b.neg[i]  = r[2];
      b.tail[i] = r[1];
      b.err[i]  = r[0];
    end
    return b;
  endfunction

  task automatic compare_all();
    chk("valid_out", 128'(valid_out), 128'(q.size() > 0));
    chk("ready_out", 128'(ready_out), 128'(q.size() < 2));
    if (q.size() > 0) begin
      chk("x", x, q[0].x);
      chk("negate", 128'(negate), 128'(q[0].neg));
      chk("tail", 128'(tail), 128'(q[0].tail));
      chk("range_err", 128'(range_err), 128'(q[0].err));
      chk("tag_out", 128'(tag_out), 128'(q[0].tag));
    end
  endtask

  // One cycle: drive at negedge, advance model at posedge, compare at next negedge.
  task automatic step(input bit vin, input logic [127:0] uv, input logic [7:0] tg,
                      input bit rin, output bit acc);
    bit xfer;
    valid_in = vin; u = uv; tag_in = tg; ready_in = rin;
    acc  = vin && (q.size() < 2);
    xfer = rin && (q.size() > 0);
    @(posedge clk);
    if (xfer) delivered.push_back(q.pop_front().tag);
    if (acc) q.push_back(make_beat(uv, tg));
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [31:0] rand_u();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000;
      2: return 32'h10000;
      3: return 32'($urandom_range(0, 2047));
      4: return 32'($urandom_range(0, 32'h1FFFF));
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [127:0] rand_vec();
    return {rand_u(), rand_u(), rand_u(), rand_u()};
  endfunction

  initial begin
    bit acc;
    logic [34:0] r;
    logic [7:0] t;
    logic [31:0] zx;
    zx = EPS ? 32'h1 : 32'h0;

    // Pin the model itself with hand-computed values.
    r = fold_ref(32'hFB00);
    chk("ref_fb00", 128'(r), 128'({32'h0500, 1'b1, 1'b1, 1'b0}));
    r = fold_ref(32'h0700);
    chk("ref_0700", 128'(r), 128'({32'h0700, 1'b0, 1'b0, 1'b0}));
    r = fold_ref(32'h8000);
    chk("ref_8000", 128'(r), 128'({32'h8000, 1'b1, 1'b0, 1'b0}));
    r = fold_ref(32'h18000);
    chk("ref_18000", 128'(r), 128'({zx, 1'b1, 1'b1, 1'b1}));

    rst = 1'b1; valid_in = 1'b0; ready_in = 1'b0; u = '0; tag_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(valid_out), 128'(0));
    chk("rst_ready", 128'(ready_out), 128'(1));
    chk("rst_x", x, 128'(0));
    chk("rst_tag", 128'(tag_out), 128'(0));
    rst = 1'b0;

    // Directed folds (ready_in high).
    step(1'b1, {4{32'h4000}}, 8'h11, 1'b1, acc);
    chk("t1_x", x, {4{32'h4000}});
    chk("t1_neg", 128'(negate), 128'(0));
    chk("t1_tail", 128'(tail), 128'(0));
    chk("t1_tag", 128'(tag_out), 128'(8'h11));

    step(1'b1, {32'h10000, 32'h7FFF, 32'hC000, 32'h8000}, 8'h22, 1'b1, acc);
    chk("t2_x", x, {zx, 32'h7FFF, 32'h4000, 32'h8000});
    chk("t2_neg", 128'(negate), 128'(4'b1011));
    chk("t2_tail", 128'(tail), 128'(4'b1000));

    step(1'b1, {32'h4000, 32'h4000, 32'h4000, 32'h18000}, 8'h33, 1'b1, acc);
    chk("t3_err", 128'(range_err), 128'(4'b0001));
    chk("t3_x0", 128'(x[31:0]), 128'(zx));
    chk("t3_neg0", 128'(negate[0]), 128'(1));

    step(1'b1, {32'h4000, 32'hFB00, 32'h0700, 32'h0500}, 8'h44, 1'b1, acc);
    chk("t4_tail", 128'(tail), 128'(4'b0101));
    chk("t4_neg", 128'(negate), 128'(4'b0100));
    chk("t4_x2", 128'(x[95:64]), 128'(32'h0500));
    step(1'b0, '0, '0, 1'b1, acc);

    // Tags 1..6 streamed with ready_in low for the first 3 cycles.
    delivered.delete();
    t = 8'd1;
    for (int c = 0; c < 20; c++) begin
      step(t <= 8'd6, rand_vec(), t, c >= 3, acc);
      if (acc) t++;
      if (c == 1) chk("t5_ready_drop", 128'(ready_out), 128'(0));
    end
    chk("t5_count", 128'(delivered.size()), 128'(6));
    for (int i = 0; i < 6 && i < delivered.size(); i++)
      chk("t5_order", 128'(delivered[i]), 128'(i + 1));

    // Reset while FULL discards both beats.
    step(1'b1, rand_vec(), 8'h61, 1'b0, acc);
    step(1'b1, rand_vec(), 8'h62, 1'b0, acc);
    chk("t6_full", 128'(ready_out), 128'(0));
    valid_in = 1'b0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    delivered.delete();
    chk("t6_valid", 128'(valid_out), 128'(0));
    chk("t6_ready", 128'(ready_out), 128'(1));
    chk("t6_x", x, 128'(0));
    chk("t6_flags", 128'({negate, tail, range_err}), 128'(0));
    chk("t6_tag", 128'(tag_out), 128'(0));
    step(1'b1, {4{32'h1234}}, 8'hA5, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b1, acc);
    chk("t6_alone", 128'(delivered.size()), 128'(1));
    if (delivered.size() > 0) chk("t6_tag_out", 128'(delivered[0]), 128'(8'hA5));

    // Random traffic with random backpressure.
    for (int c = 0; c < 2000; c++) begin
      step($urandom_range(0, 3) != 0, rand_vec(), 8'($urandom), $urandom_range(0, 2) != 0, acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
